// File: rtl/sram_access_arbiter_if.sv
// rtl/sram_access_arbiter_if.sv - requester handshakes and SRAM pin bundle for the arbiter
interface sram_access_arbiter_if #(
  parameter int AW = 20,
  parameter int DW = 16
);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;

  logic [AW-1:0] addr;
  logic          CE_n;
  logic          OE_n;
  logic          WE_n;
  logic          UB_n;
  logic          LB_n;
  logic [DW-1:0] sram_data_out;
  logic          sram_data_oe;
  logic [DW-1:0] sram_data_in;
  logic          busy;

  // requesters and the SRAM device side
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_data_in,
    input  rd_ack, rd_data, rd_valid, wr_ack, addr, CE_n, OE_n, WE_n, UB_n, LB_n,
           sram_data_out, sram_data_oe, busy
  );

  // the arbiter itself
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_data_in,
    output rd_ack, rd_data, rd_valid, wr_ack, addr, CE_n, OE_n, WE_n, UB_n, LB_n,
           sram_data_out, sram_data_oe, busy
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - round-robin read/write arbiter driving a 16-bit async SRAM
module sram_access_arbiter #(
  parameter int AW       = 20,
  parameter int DW       = 16,
  parameter int RD_WAIT  = 2,
  parameter int WR_PULSE = 2
) (
  input logic                 clk,
  input logic                 rst,
  sram_access_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

  localparam logic [3:0] RD_CNT = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_PULSE - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       last_wr;
  logic       grant_rd;
  logic       grant_wr;

  // Contention goes to whichever side did not win last time.
  always_comb begin
    grant_rd = bus.rd_req && (!bus.wr_req || last_wr);
    grant_wr = bus.wr_req && !grant_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      wait_cnt          <= 4'd0;
      last_wr           <= 1'b1;
      bus.addr          <= {AW{1'b0}};
      bus.CE_n          <= 1'b1;
      bus.OE_n          <= 1'b1;
      bus.WE_n          <= 1'b1;
      bus.UB_n          <= 1'b1;
      bus.LB_n          <= 1'b1;
      bus.sram_data_out <= {DW{1'b0}};
      bus.sram_data_oe  <= 1'b0;
      bus.rd_ack        <= 1'b0;
      bus.wr_ack        <= 1'b0;
      bus.rd_valid      <= 1'b0;
      bus.rd_data       <= {DW{1'b0}};
      bus.busy          <= 1'b0;
    end else begin
      bus.rd_ack   <= 1'b0;
      bus.wr_ack   <= 1'b0;
      bus.rd_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_rd) begin
            state    <= S_RD;
            last_wr  <= 1'b0;
            wait_cnt <= RD_CNT;
            bus.rd_ack <= 1'b1;
            bus.addr   <= bus.rd_addr;
            bus.CE_n   <= 1'b0;
            bus.OE_n   <= 1'b0;
            bus.WE_n   <= 1'b1;
            bus.UB_n   <= 1'b0;
            bus.LB_n   <= 1'b0;
            bus.busy   <= 1'b1;
          end else if (grant_wr) begin
            state    <= S_WR_SETUP;
            last_wr  <= 1'b1;
            bus.wr_ack        <= 1'b1;
            bus.addr          <= bus.wr_addr;
            bus.sram_data_out <= bus.wr_data;
            bus.sram_data_oe  <= 1'b1;
            bus.CE_n          <= 1'b0;
            bus.OE_n          <= 1'b1;
            bus.WE_n          <= 1'b1;
            bus.UB_n          <= 1'b0;
            bus.LB_n          <= 1'b0;
            bus.busy          <= 1'b1;
          end
        end

        S_RD: begin
          if (wait_cnt == 4'd0) begin
            state        <= S_IDLE;
            bus.rd_data  <= bus.sram_data_in;
            bus.rd_valid <= 1'b1;
            bus.CE_n     <= 1'b1;
            bus.OE_n     <= 1'b1;
            bus.UB_n     <= 1'b1;
            bus.LB_n     <= 1'b1;
            bus.busy     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        // Address and data were set up a cycle earlier, so dropping WE_n here is safe.
        S_WR_SETUP: begin
          state    <= S_WR_PULSE;
          wait_cnt <= WR_CNT;
          bus.WE_n <= 1'b0;
        end

        S_WR_PULSE: begin
          if (wait_cnt == 4'd0) begin
            state    <= S_WR_HOLD;
            bus.WE_n <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_WR_HOLD: begin
          state            <= S_IDLE;
          bus.sram_data_oe <= 1'b0;
          bus.CE_n         <= 1'b1;
          bus.UB_n         <= 1'b1;
          bus.LB_n         <= 1'b1;
          bus.busy         <= 1'b0;
        end

        default: begin
          state            <= S_IDLE;
          bus.sram_data_oe <= 1'b0;
          bus.CE_n         <= 1'b1;
          bus.OE_n         <= 1'b1;
          bus.WE_n         <= 1'b1;
          bus.UB_n         <= 1'b1;
          bus.LB_n         <= 1'b1;
          bus.busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - scoreboard bench for sram_access_arbiter
module tb_sram_access_arbiter;

  localparam int K_RDACK = 1;
  localparam int K_WRACK = 2;
  localparam int K_RDV   = 3;

  typedef struct {
    int          kind;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [15:0] mem0 [logic [19:0]];
  logic [15:0] mem1 [logic [19:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_access_arbiter_if #(.AW(20), .DW(16)) b0 ();
  sram_access_arbiter_if #(.AW(20), .DW(16)) b1 ();

  sram_access_arbiter #(.AW(20), .DW(16), .RD_WAIT(2), .WR_PULSE(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  sram_access_arbiter #(.AW(20), .DW(16), .RD_WAIT(1), .WR_PULSE(2)) u_seq (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  function automatic logic [15:0] rd0(input logic [19:0] a);
    return mem0.exists(a) ? mem0[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] rd1(input logic [19:0] a);
    return mem1.exists(a) ? mem1[a] : 16'h0000;
  endfunction

  // Asynchronous SRAM models: pins are registered by the DUT, so evaluate mid-cycle
  always @(negedge clk) begin
    if (!b0.CE_n && !b0.WE_n && b0.sram_data_oe) mem0[b0.addr] = b0.sram_data_out;
    b0.sram_data_in = (!b0.CE_n && !b0.OE_n) ? rd0(b0.addr) : 16'hDEAD;
    if (!b1.CE_n && !b1.WE_n && b1.sram_data_oe) mem1[b1.addr] = b1.sram_data_out;
    b1.sram_data_in = (!b1.CE_n && !b1.OE_n) ? rd1(b1.addr) : 16'hDEAD;
  end

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int w, input logic ra, input logic wa, input logic rv,
                     input logic [15:0] rd);
    int   k;
    exp_t e;
    if (int'(ra) + int'(wa) + int'(rv) > 1) begin
      vectors++;
      errors++;
      $display("FAIL evt%0d_multi: got ack/valid %b%b%b together at cycle %0d, required one",
               w, ra, wa, rv, cyc);
    end
    k = ra ? K_RDACK : wa ? K_WRACK : rv ? K_RDV : 0;
    if (k == 0) return;
    vectors++;
    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL evt%0d_unexpected: got kind %0d at cycle %0d, required none", w, k, cyc);
      return;
    end
    if (w == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (e.kind != k || e.cyc != cyc || (k == K_RDV && rd !== e.data)) begin
      errors++;
      $display("FAIL evt%0d: got kind %0d cycle %0d data %h, required kind %0d cycle %0d data %h",
               w, k, cyc, rd, e.kind, e.cyc, e.data);
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.rd_ack, b0.wr_ack, b0.rd_valid, b0.rd_data);
    mon(1, b1.rd_ack, b1.wr_ack, b1.rd_valid, b1.rd_data);
  end

  // While WE_n is low, OE_n must stay high and address/data must not move
  logic [19:0] pa;
  logic [15:0] pd;
  logic        pwe = 1'b0;
  always @(negedge clk) begin
    if (!b0.WE_n) begin
      vectors++;
      if (!b0.OE_n || (pwe && (b0.addr !== pa || b0.sram_data_out !== pd))) begin
        errors++;
        $display("FAIL we_window: got OE_n=%b addr=%h data=%h, required OE_n=1 addr=%h data=%h",
                 b0.OE_n, b0.addr, b0.sram_data_out, pa, pd);
      end
    end
    pwe = !b0.WE_n;
    pa  = b0.addr;
    pd  = b0.sram_data_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [19:0] a, input logic [15:0] d);
    int c0;
    c0 = cyc;
    b0.rd_req  = 1'b1;
    b0.rd_addr = a;
    q0.push_back('{K_RDACK, 16'h0000, c0 + 1});
    q0.push_back('{K_RDV, d, c0 + 3});
    step();
    chk("rd_c1_pins", {36'd0, b0.OE_n, b0.WE_n, b0.CE_n, b0.busy}, {36'd0, 4'b0101});
    chk("rd_c1_addr", {20'd0, b0.addr}, {20'd0, a});
    step();
    b0.rd_req = 1'b0;
    chk("rd_c2_oe_n", {39'd0, b0.OE_n}, 40'd0);
    step();
    chk("rd_c3_pins", {37'd0, b0.OE_n, b0.WE_n, b0.busy}, {37'd0, 3'b110});
    chk("rd_data", {24'd0, b0.rd_data}, {24'd0, d});
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    b0.rd_req = 1'b0; b0.rd_addr = '0; b0.wr_req = 1'b0; b0.wr_addr = '0; b0.wr_data = '0;
    b1.rd_req = 1'b0; b1.rd_addr = '0; b1.wr_req = 1'b0; b1.wr_addr = '0; b1.wr_data = '0;
    b0.sram_data_in = 16'hDEAD;
    b1.sram_data_in = 16'hDEAD;

    // reset state after 3 cycles of rst
    repeat (3) step();
    chk("reset_pins", {33'd0, b0.CE_n, b0.OE_n, b0.WE_n, b0.UB_n, b0.LB_n, b0.sram_data_oe, b0.busy},
        {33'd0, 7'b1111100});
    chk("reset_outs", {b0.addr, b0.rd_data, b0.rd_ack, b0.wr_ack, b0.rd_valid, b0.sram_data_out[0]},
        40'd0);
    chk("reset_dout", {24'd0, b0.sram_data_out}, 40'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("idle_pins", {33'd0, b0.CE_n, b0.OE_n, b0.WE_n, b0.UB_n, b0.LB_n, b0.sram_data_oe, b0.busy},
          {33'd0, 7'b1111100});
    end

    // single read
    mem0[20'h34BC] = 16'h1A2B;
    do_read(20'h34BC, 16'h1A2B);

    // single write
    c0 = cyc;
    b0.wr_req  = 1'b1;
    b0.wr_addr = 20'h34C0;
    b0.wr_data = 16'h0ABC;
    q0.push_back('{K_WRACK, 16'h0000, c0 + 1});
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 2) b0.wr_req = 1'b0;
      chk("wr_we_n", {39'd0, b0.WE_n}, {39'd0, (i == 2 || i == 3) ? 1'b0 : 1'b1});
      chk("wr_oe", {39'd0, b0.sram_data_oe}, {39'd0, (i <= 4) ? 1'b1 : 1'b0});
      if (i <= 4) chk("wr_addr_data", {4'd0, b0.addr, b0.sram_data_out}, {4'd0, 20'h34C0, 16'h0ABC});
    end
    chk("wr_mem", {24'd0, rd0(20'h34C0)}, {24'd0, 16'h0ABC});

    // both requesters held high from reset: read, write, read, write
    mem0[20'h00100] = 16'h5555;
    rst = 1'b1;
    b0.rd_req = 1'b1; b0.rd_addr = 20'h00100;
    b0.wr_req = 1'b1; b0.wr_addr = 20'h00200; b0.wr_data = 16'h7777;
    step();
    step();
    rst = 1'b0;
    c0 = cyc;
    q0.push_back('{K_RDACK, 16'h0000, c0 + 1});
    q0.push_back('{K_RDV, 16'h5555, c0 + 3});
    q0.push_back('{K_WRACK, 16'h0000, c0 + 4});
    q0.push_back('{K_RDACK, 16'h0000, c0 + 9});
    q0.push_back('{K_RDV, 16'h5555, c0 + 11});
    q0.push_back('{K_WRACK, 16'h0000, c0 + 12});
    repeat (13) step();
    b0.rd_req = 1'b0;
    b0.wr_req = 1'b0;
    repeat (4) step();
    chk("alt_busy", {39'd0, b0.busy}, 40'd0);
    chk("alt_mem", {24'd0, rd0(20'h00200)}, {24'd0, 16'h7777});

    // reset during the write strobe
    mem0[20'h00300] = 16'h1111;
    mem0[20'h00301] = 16'h2222;
    c0 = cyc;
    b0.wr_req  = 1'b1;
    b0.wr_addr = 20'h00300;
    b0.wr_data = 16'h9999;
    q0.push_back('{K_WRACK, 16'h0000, c0 + 1});
    step();
    step();
    b0.wr_req = 1'b0;
    chk("rstw_we_low", {39'd0, b0.WE_n}, 40'd0);
    rst = 1'b1;
    step();
    chk("rstw_pins", {35'd0, b0.WE_n, b0.CE_n, b0.OE_n, b0.sram_data_oe, b0.busy},
        {35'd0, 5'b11100});
    rst = 1'b0;
    repeat (3) step();
    chk("rstw_mem_target", {24'd0, rd0(20'h00300)}, {24'd0, 16'h9999});
    chk("rstw_mem_neighbour", {24'd0, rd0(20'h00301)}, {24'd0, 16'h2222});
    do_read(20'h00301, 16'h2222);

    // 16 back-to-back reads on the RD_WAIT=1 instance
    for (int i = 0; i < 16; i++) mem1[20'(i)] = 16'hC000 | 16'(i * 16'h0101);
    step();
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      b1.rd_req  = 1'b1;
      b1.rd_addr = 20'(i);
      q1.push_back('{K_RDACK, 16'h0000, c0 + 2 * i + 1});
      q1.push_back('{K_RDV, 16'hC000 | 16'(i * 16'h0101), c0 + 2 * i + 2});
      step();
      step();
    end
    b1.rd_req = 1'b0;

    for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) step();
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d events outstanding, required 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
